// File: rtl/branch_resolve_if.sv
// Execute-stage branch resolution bus: upstream instruction/flags, downstream result.
// Optional BRANCH_STATS_EN adds the three 32-bit statistics counters.
interface branch_resolve_if #(
  parameter int WORDSIZE = 64
);
  // Both sides use valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; valid must not depend on ready.
  logic                in_valid;
  logic                in_ready;
  logic                is_branch;
  logic                is_jal;
  logic                is_jalr;
  logic [2:0]          funct3;
  logic [WORDSIZE-1:0] pc;
  logic [WORDSIZE-1:0] imm;
  logic [WORDSIZE-1:0] alu_result;
  logic                flag_equal;
  logic                flag_not_equal;
  logic                flag_greater;
  logic                flag_less;
  logic                flag_u_equal;
  logic                flag_u_greater;
  logic                flag_u_less;
  logic                pred_taken;
  logic [WORDSIZE-1:0] pred_target;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic                taken;
  logic [WORDSIZE-1:0] target;
  logic [WORDSIZE-1:0] link;
  logic                mispredict;
  logic                misaligned;
  logic                redirect;
`ifdef BRANCH_STATS_EN
  logic [31:0]         stat_branches;
  logic [31:0]         stat_taken;
  logic [31:0]         stat_mispredicts;
`endif

  modport master (
    output in_valid, is_branch, is_jal, is_jalr, funct3, pc, imm, alu_result,
           flag_equal, flag_not_equal, flag_greater, flag_less,
           flag_u_equal, flag_u_greater, flag_u_less,
           pred_taken, pred_target, flush, out_ready,
    input  in_ready, out_valid, taken, target, link, mispredict, misaligned, redirect
`ifdef BRANCH_STATS_EN
    , input stat_branches, stat_taken, stat_mispredicts
`endif
  );

  modport slave (
    input  in_valid, is_branch, is_jal, is_jalr, funct3, pc, imm, alu_result,
           flag_equal, flag_not_equal, flag_greater, flag_less,
           flag_u_equal, flag_u_greater, flag_u_less,
           pred_taken, pred_target, flush, out_ready,
    output in_ready, out_valid, taken, target, link, mispredict, misaligned, redirect
`ifdef BRANCH_STATS_EN
    , output stat_branches, stat_taken, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branch/JAL/JALR direction and target from ALU flags, one registered stage.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int WORDSIZE = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  branch_resolve_if.slave bus
);
  localparam logic [WORDSIZE-1:0] FOUR     = {{(WORDSIZE-3){1'b0}}, 3'b100};
  localparam logic [WORDSIZE-1:0] BIT0_CLR = ~{{(WORDSIZE-1){1'b0}}, 1'b1};

  logic                capture;
  logic                handshake;
  logic                sel_jalr;
  logic                sel_jal;
  logic                sel_branch;
  logic                cond;
  logic                nxt_taken;
  logic [WORDSIZE-1:0] nxt_target;
  logic [WORDSIZE-1:0] nxt_link;
  logic                nxt_mispredict;
  logic                nxt_misaligned;

  logic                out_valid_q;
  logic                taken_q;
  logic [WORDSIZE-1:0] target_q;
  logic [WORDSIZE-1:0] link_q;
  logic                mispredict_q;
  logic                misaligned_q;
  logic                is_branch_q;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
  assign handshake    = out_valid_q && bus.out_ready;

  always_comb begin
    sel_jalr   = bus.is_jalr;
    sel_jal    = !bus.is_jalr && bus.is_jal;
    sel_branch = !bus.is_jalr && !bus.is_jal && bus.is_branch;

    cond = 1'b0;
    case (bus.funct3)
      3'b000:  cond = bus.flag_equal;
      3'b001:  cond = bus.flag_not_equal;
      3'b100:  cond = bus.flag_less;
      3'b101:  cond = bus.flag_greater || bus.flag_equal;
      3'b110:  cond = bus.flag_u_less;
      3'b111:  cond = bus.flag_u_greater || bus.flag_u_equal;
      default: cond = 1'b0;
    endcase

    nxt_taken = sel_jalr || sel_jal || (sel_branch && cond);
    nxt_link  = bus.pc + FOUR;

    // JALR clears bit 0 of rs1+imm; everything else taken goes to pc+imm.
    if (sel_jalr)       nxt_target = bus.alu_result & BIT0_CLR;
    else if (nxt_taken) nxt_target = bus.pc + bus.imm;
    else                nxt_target = nxt_link;

    nxt_mispredict = (nxt_taken != bus.pred_taken) ||
                     (nxt_taken && (nxt_target != bus.pred_target));
    nxt_misaligned = nxt_taken && nxt_target[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
      is_branch_q  <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
    end else if (capture) begin
      out_valid_q  <= 1'b1;
      taken_q      <= nxt_taken;
      target_q     <= nxt_target;
      link_q       <= nxt_link;
      mispredict_q <= nxt_mispredict;
      misaligned_q <= nxt_misaligned;
      is_branch_q  <= sel_branch;
    end else if (handshake) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.taken      = taken_q;
  assign bus.target     = target_q;
  assign bus.link       = link_q;
  assign bus.mispredict = mispredict_q;
  assign bus.misaligned = misaligned_q;
  // A misaligned target traps instead of redirecting fetch.
  assign bus.redirect   = out_valid_q && mispredict_q && !misaligned_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] cnt_branches;
  logic [31:0] cnt_taken;
  logic [31:0] cnt_mispredicts;
  logic        count_en;

  // A result killed by flush in the same cycle is not counted.
  assign count_en = handshake && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branches    <= '0;
      cnt_taken       <= '0;
      cnt_mispredicts <= '0;
    end else if (count_en) begin
      if (is_branch_q && (cnt_branches != 32'hFFFF_FFFF))
        cnt_branches <= cnt_branches + 32'd1;
      if (taken_q && (cnt_taken != 32'hFFFF_FFFF))
        cnt_taken <= cnt_taken + 32'd1;
      if (mispredict_q && (cnt_mispredicts != 32'hFFFF_FFFF))
        cnt_mispredicts <= cnt_mispredicts + 32'd1;
    end
  end

  assign bus.stat_branches    = cnt_branches;
  assign bus.stat_taken       = cnt_taken;
  assign bus.stat_mispredicts = cnt_mispredicts;
`endif
endmodule
